axi_slave_rd_mem: RTL
=====================

// Module: axi_slave_rd_mem
// PURPOSE
//  AXI4 read-slave with internal word memory, AR request queue and full burst address generation.
//  Accepts AR requests into a small FIFO; a data engine returns len+1 beats on R per request, in order.
//  Supports FIXED/INCR/WRAP bursts and narrow sizes; reports SLVERR instead of hanging.
//  Sits behind the interconnect as the read half of the on-chip memory slave; a backdoor port loads memory.
// PARAMETERS
//  ADDR_BITS      32   byte address width
//  DATA_BITS      32   R data width; power of 2, >= 8
//  LEN_BITS       8    ar_len width (beats = ar_len+1)
//  SIZE_BITS      3    ar_size width
//  MEM_DEPTH      256  memory words of DATA_BITS
//  AR_FIFO_DEPTH  2    queued AR requests; power of 2, >= 2
//  ID_BITS        4    ID width (used only with AXI_RD_ID_EN)
// PORTS
//  aclk      in   1             clock, all logic on rising edge
//  areset    in   1             asynchronous, active-high reset
//  ar_valid  in   1             AR request valid
//  ar_ready  out  1             AR accept
//  ar_addr   in   ADDR_BITS     start byte address
//  ar_len    in   LEN_BITS      beats-1
//  ar_size   in   SIZE_BITS     log2 bytes per beat
//  ar_burst  in   2             00 FIXED, 01 INCR, 10 WRAP, 11 reserved
//  ar_cache  in   4             stored in queue, no effect
//  r_valid   out  1             beat valid
//  r_ready   in   1             beat accept
//  r_data    out  DATA_BITS     full memory word at beat address
//  r_last    out  1             final beat of burst
//  r_resp    out  2             00 OKAY, 10 SLVERR
//  mem_we    in   1             backdoor write enable
//  mem_waddr in   clog2(MEM_DEPTH) backdoor word index
//  mem_wdata in   DATA_BITS     backdoor write data
// BEHAVIOUR
//  Reset: ar_ready=0 while areset high; r_valid=0, r_last=0, r_resp=00, r_data=0; FIFO emptied; state IDLE.
//  Reset mid-burst drops in-flight and queued requests. Memory array is not reset.
//  AR: ar_ready = !areset && !fifo_full (combinational). Push on ar_valid&&ar_ready. No push-on-full bypass.
//  Engine FSM: IDLE -> BURST when FIFO non-empty (pop, load addr/len/size/burst, present beat 0).
//   BURST: on r_valid&&r_ready with remaining>0, load next beat same edge (no intra-burst bubble).
//   On r_valid&&r_ready with r_last=1 -> IDLE; next queued burst's first beat follows 1 cycle later.
//  Latency: AR handshake at edge E0 into empty FIFO with engine IDLE -> r_valid=1 from edge E1.
//  R hold: while r_valid && !r_ready, r_data/r_last/r_resp stay stable.
//  r_last=1 exactly on beat ar_len (len 0 -> single beat with r_last=1).
//  Address gen, bytes=1<<size: FIXED keep addr; INCR addr+bytes (4KB crossing not checked);
//   WRAP: B=(len+1)*bytes, next=(addr & ~(B-1)) | ((addr+bytes) & (B-1)).
//  Word index = addr >> log2(DATA_BITS/8); narrow beats return the full word.
//  SLVERR (whole burst, r_data=0, all len+1 beats still returned): burst=11; size>log2(DATA_BITS/8);
//   WRAP with len not in {1,3,7,15}.
//  SLVERR (per beat, r_data=0): word index >= MEM_DEPTH; other beats unaffected.
//  Backdoor write to word being read in same cycle: beat returns old data.
// CONFIGURATION
//  AXI_RD_ID_EN defined: adds ar_id in [ID_BITS] and r_id out [ID_BITS]; ID stored per FIFO entry,
//   r_id equals ar_id of the burst on every beat; r_id reset 0.
//  Not defined: no ID ports or storage; ID_BITS ignored.
// STRUCTURE
//  axi_pkg: burst_t enum (FIXED/INCR/WRAP/RSVD), resp constants OKAY/SLVERR, ar_req_t struct
//   (addr,len,size,burst,cache[,id]), next-address function prototype constants.
//  Sub-module axi_rd_addr_gen: combinational next-address and wrap-legality/size-error logic.
//  Top keeps AR FIFO, FSM, beat counter, memory array, R output registers.
// TESTING
//  INCR len=3 size=2 addr=0x10, mem[4..7]=A..D, r_ready=1 -> A,B,C,D back-to-back, r_last on D, resp 00.
//  WRAP len=3 size=2 addr=0x18 -> word order 6,7,4,5; r_last on 4th; resp 00.
//  FIXED len=2 addr=0x8, r_ready toggling 1,0,1,0 -> word 2 thrice, data held stable while r_ready=0.
//  Three ARs with r_ready=0, depth 2 -> ar_ready drops after 2nd queued; 3rd accepted after first pop.
//  burst=11 len=1 -> two beats r_data=0 resp 10, r_last on 2nd; INCR crossing MEM_DEPTH -> only OOR beats 10.
//  areset pulse mid-burst -> r_valid=0 next cycle, FIFO empty; new AR afterwards served normally.

Source files
------------

// File: rtl/axi_pkg.sv
// axi_pkg: shared types for the read half of the on-chip AXI memory slave.
// Optional feature macro: AXI_RD_ID_EN (adds an ID field to each queued request).
// The request struct is sized for the widest supported configuration; narrower
// module parameters are zero-extended into it and truncated back out.
package axi_pkg;

   localparam int AXI_ADDR_MAX = 32;
   localparam int AXI_LEN_MAX  = 8;
   localparam int AXI_SIZE_MAX = 3;
   localparam int AXI_ID_MAX   = 4;

   typedef enum logic [1:0] {
      BURST_FIXED = 2'b00,
      BURST_INCR  = 2'b01,
      BURST_WRAP  = 2'b10,
      BURST_RSVD  = 2'b11
   } burst_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef struct packed {
      logic [AXI_ADDR_MAX-1:0] addr;
      logic [AXI_LEN_MAX-1:0]  len;
      logic [AXI_SIZE_MAX-1:0] size;
      burst_t                  burst;
      logic [3:0]              cache;
`ifdef AXI_RD_ID_EN
      logic [AXI_ID_MAX-1:0]   id;
`endif
   } ar_req_t;

   // A wrapping burst must span exactly 2, 4, 8 or 16 beats
   function automatic logic wrap_len_legal(input logic [AXI_LEN_MAX-1:0] len);
      return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
   endfunction

endpackage

// File: rtl/axi_rd_addr_gen.sv
// axi_rd_addr_gen: combinational successor-address and burst-legality logic.
// Given the current beat address and burst attributes it produces the next
// beat address and flags bursts that must be answered entirely with SLVERR.
module axi_rd_addr_gen
   import axi_pkg::*;
#(
   parameter int ADDR_BITS = 32,
   parameter int DATA_BITS = 32,
   parameter int LEN_BITS  = 8,
   parameter int SIZE_BITS = 3
) (
   input  logic [ADDR_BITS-1:0] addr,
   input  logic [LEN_BITS-1:0]  len,
   input  logic [SIZE_BITS-1:0] size,
   input  burst_t               burst,
   output logic [ADDR_BITS-1:0] next_addr,
   output logic                 burst_err
);

   localparam int BYTE_LSB = $clog2(DATA_BITS / 8);

   logic [ADDR_BITS-1:0] beat_bytes;
   logic [ADDR_BITS-1:0] incr_addr;
   logic [ADDR_BITS-1:0] wrap_mask;
   logic                 size_err;
   logic                 wrap_err;

   // Beat stride, linear successor and the byte mask of the wrap window
   always_comb begin
      beat_bytes = ADDR_BITS'(1) << size;
      incr_addr  = addr + beat_bytes;
      wrap_mask  = ((ADDR_BITS'(len) + ADDR_BITS'(1)) * beat_bytes) - ADDR_BITS'(1);
   end

   // Choose the successor by burst type; reserved bursts just hold the address
   always_comb begin
      next_addr = addr;
      case (burst)
         BURST_INCR: next_addr = incr_addr;
         BURST_WRAP: next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
         default:    next_addr = addr;
      endcase
   end

   // Whole-burst errors: reserved type, beat wider than the bus, illegal wrap length
   always_comb begin
      size_err  = size > SIZE_BITS'(BYTE_LSB);
      wrap_err  = (burst == BURST_WRAP) && !wrap_len_legal(AXI_LEN_MAX'(len));
      burst_err = (burst == BURST_RSVD) || size_err || wrap_err;
   end

endmodule

// File: rtl/axi_slave_rd_mem.sv
// axi_slave_rd_mem: AXI4 read slave with internal word memory.
// AR requests queue in a small FIFO; a two-state engine pops one request at a
// time and returns len+1 beats on R, in order, with FIXED/INCR/WRAP addressing.
// Malformed bursts and out-of-range words answer SLVERR with zero data.
// Optional feature macro: AXI_RD_ID_EN (adds ar_id/r_id carried per request).
module axi_slave_rd_mem
   import axi_pkg::*;
#(
   parameter int ADDR_BITS     = 32,
   parameter int DATA_BITS     = 32,
   parameter int LEN_BITS      = 8,
   parameter int SIZE_BITS     = 3,
   parameter int MEM_DEPTH     = 256,
   parameter int AR_FIFO_DEPTH = 2,
   parameter int ID_BITS       = 4
) (
   input  logic                         aclk,
   input  logic                         areset,
   input  logic                         ar_valid,
   output logic                         ar_ready,
   input  logic [ADDR_BITS-1:0]         ar_addr,
   input  logic [LEN_BITS-1:0]          ar_len,
   input  logic [SIZE_BITS-1:0]         ar_size,
   input  logic [1:0]                   ar_burst,
   input  logic [3:0]                   ar_cache,
`ifdef AXI_RD_ID_EN
   input  logic [ID_BITS-1:0]           ar_id,
   output logic [ID_BITS-1:0]           r_id,
`endif
   output logic                         r_valid,
   input  logic                         r_ready,
   output logic [DATA_BITS-1:0]         r_data,
   output logic                         r_last,
   output logic [1:0]                   r_resp,
   input  logic                         mem_we,
   input  logic [$clog2(MEM_DEPTH)-1:0] mem_waddr,
   input  logic [DATA_BITS-1:0]         mem_wdata
);

   localparam int BYTE_LSB = $clog2(DATA_BITS / 8);
   localparam int MEM_AW   = $clog2(MEM_DEPTH);
   localparam int PTR_BITS = $clog2(AR_FIFO_DEPTH);

   typedef enum logic {S_IDLE, S_BURST} state_t;

   state_t               state, state_next;
   ar_req_t              fifo_q [AR_FIFO_DEPTH];
   ar_req_t              push_req, head_req;
   logic [PTR_BITS-1:0]  wr_ptr, rd_ptr;
   logic [PTR_BITS:0]    fifo_count;
   logic                 fifo_full, fifo_empty, push, pop;
   logic                 load_first, load_next;

   logic [DATA_BITS-1:0] mem_q [MEM_DEPTH];

   logic [ADDR_BITS-1:0] cur_addr;
   logic [LEN_BITS-1:0]  cur_len, rem;
   logic [SIZE_BITS-1:0] cur_size;
   burst_t               cur_burst;
   logic                 cur_err;

   logic [ADDR_BITS-1:0] gen_addr, gen_next, beat_addr, word_idx;
   logic [LEN_BITS-1:0]  gen_len;
   logic [SIZE_BITS-1:0] gen_size;
   burst_t               gen_burst;
   logic                 gen_err, beat_err;
   logic                 unused_cache;

   assign fifo_full  = (fifo_count == (PTR_BITS+1)'(AR_FIFO_DEPTH));
   assign fifo_empty = (fifo_count == '0);
   assign ar_ready   = !areset && !fifo_full;
   assign push       = ar_valid && ar_ready;
   assign head_req   = fifo_q[rd_ptr];
   assign unused_cache = ^head_req.cache;

   // Pack the incoming AR fields into a queue entry
   always_comb begin
      push_req       = '0;
      push_req.addr  = AXI_ADDR_MAX'(ar_addr);
      push_req.len   = AXI_LEN_MAX'(ar_len);
      push_req.size  = AXI_SIZE_MAX'(ar_size);
      push_req.burst = burst_t'(ar_burst);
      push_req.cache = ar_cache;
`ifdef AXI_RD_ID_EN
      push_req.id    = AXI_ID_MAX'(ar_id);
`endif
   end

   // Queue storage needs no reset; only the pointers define occupancy
   always_ff @(posedge aclk) begin
      if (push) fifo_q[wr_ptr] <= push_req;
   end

   // Queue pointers and occupancy count
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // Backdoor loader; a read of the same word this cycle still sees the old value
   always_ff @(posedge aclk) begin
      if (mem_we) mem_q[mem_waddr] <= mem_wdata;
   end

   // In IDLE the address generator vets the queue head; in BURST it steps the live burst
   assign gen_addr  = (state == S_IDLE) ? ADDR_BITS'(head_req.addr) : cur_addr;
   assign gen_len   = (state == S_IDLE) ? LEN_BITS'(head_req.len)   : cur_len;
   assign gen_size  = (state == S_IDLE) ? SIZE_BITS'(head_req.size) : cur_size;
   assign gen_burst = (state == S_IDLE) ? head_req.burst            : cur_burst;

   axi_rd_addr_gen #(
      .ADDR_BITS (ADDR_BITS),
      .DATA_BITS (DATA_BITS),
      .LEN_BITS  (LEN_BITS),
      .SIZE_BITS (SIZE_BITS)
   ) u_addr_gen (
      .addr      (gen_addr),
      .len       (gen_len),
      .size      (gen_size),
      .burst     (gen_burst),
      .next_addr (gen_next),
      .burst_err (gen_err)
   );

   // Address and error status of the beat about to be presented on R
   always_comb begin
      beat_addr = load_first ? ADDR_BITS'(head_req.addr) : gen_next;
      word_idx  = beat_addr >> BYTE_LSB;
      beat_err  = (load_first ? gen_err : cur_err) || (word_idx >= ADDR_BITS'(MEM_DEPTH));
   end

   // Engine state register
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) state <= S_IDLE;
      else        state <= state_next;
   end

   // Engine next state: pop in IDLE, advance on each accepted beat, leave after the last
   always_comb begin
      state_next = state;
      pop        = 1'b0;
      load_first = 1'b0;
      load_next  = 1'b0;
      case (state)
         S_IDLE: begin
            if (!fifo_empty) begin
               pop        = 1'b1;
               load_first = 1'b1;
               state_next = S_BURST;
            end
         end
         S_BURST: begin
            if (r_valid && r_ready) begin
               if (r_last) state_next = S_IDLE;
               else        load_next  = 1'b1;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Burst context and R output registers; outputs only change on load or acceptance
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         cur_addr  <= '0;
         cur_len   <= '0;
         cur_size  <= '0;
         cur_burst <= BURST_FIXED;
         cur_err   <= 1'b0;
         rem       <= '0;
         r_valid   <= 1'b0;
         r_last    <= 1'b0;
         r_resp    <= RESP_OKAY;
         r_data    <= '0;
`ifdef AXI_RD_ID_EN
         r_id      <= '0;
`endif
      end else if (load_first) begin
         cur_addr  <= beat_addr;
         cur_len   <= LEN_BITS'(head_req.len);
         cur_size  <= SIZE_BITS'(head_req.size);
         cur_burst <= head_req.burst;
         cur_err   <= gen_err;
         rem       <= LEN_BITS'(head_req.len);
         r_valid   <= 1'b1;
         r_last    <= (LEN_BITS'(head_req.len) == '0);
         r_resp    <= beat_err ? RESP_SLVERR : RESP_OKAY;
         r_data    <= beat_err ? '0 : mem_q[word_idx[MEM_AW-1:0]];
`ifdef AXI_RD_ID_EN
         r_id      <= ID_BITS'(head_req.id);
`endif
      end else if (load_next) begin
         cur_addr  <= beat_addr;
         rem       <= rem - 1'b1;
         r_last    <= (rem == LEN_BITS'(1));
         r_resp    <= beat_err ? RESP_SLVERR : RESP_OKAY;
         r_data    <= beat_err ? '0 : mem_q[word_idx[MEM_AW-1:0]];
      end else if (r_valid && r_ready) begin
         r_valid   <= 1'b0;
         r_last    <= 1'b0;
      end
   end

`ifndef AXI_RD_ID_EN
   // Without IDs the width parameter has no hardware behind it
   logic [ID_BITS-1:0] unused_id;
   assign unused_id = '0;
`endif

endmodule
